// File: rtl/uart_rx_pkg.sv
// Shared 8N1 frame-format constants for the UART transmitter/receiver pair.
// Both ends import this package so their framing cannot drift apart.
package uart_rx_pkg;

  localparam int DEFAULT_CLOCK_FREQ = 50_000_000;
  localparam int DEFAULT_BAUD_RATE  = 1_000_000;

  localparam int   DATA_BITS  = 8;
  localparam int   START_BITS = 1;
  localparam int   STOP_BITS  = 1;
  localparam logic LINE_IDLE  = 1'b1;
  localparam int   BAUD_CNT_W = 13;

  function automatic int clocks_per_bit(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// The reset value lets callers preload the line's idle level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start qualified at mid-bit, data sampled at bit centres,
// stop bit checked; one-cycle rx_valid per good byte or frame_err per bad stop.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLOCK_FREQ = DEFAULT_CLOCK_FREQ,
  parameter int BAUD_RATE  = DEFAULT_BAUD_RATE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err,
  output logic [2:0] dbg_state_o
);

  localparam int BAUD_TICK = clocks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int HALF_TICK = BAUD_TICK / 2;

  localparam logic [BAUD_CNT_W-1:0] BAUD_LAST = BAUD_CNT_W'(BAUD_TICK - 1);
  localparam logic [BAUD_CNT_W-1:0] HALF_LAST = BAUD_CNT_W'(HALF_TICK - 1);
  localparam logic [2:0]            LAST_BIT  = 3'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE = 3'd4;

  logic                  rx_s;
  logic [2:0]            state_q, state_d;
  logic [BAUD_CNT_W-1:0] baud_q, baud_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            shift_q, shift_d;
  logic [7:0]            data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
  logic                  busy_q, busy_d;

  sync_2ff #(.RESET_VAL(LINE_IDLE)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (baud_q == HALF_LAST) begin
          baud_d = '0;
          // A line that is high again at mid-start was a glitch, not a frame.
          if (!rx_s) begin
            state_d = S_DATA;
            bit_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d         = '0;
          shift_d[bit_q] = rx_s;
          if (bit_q == LAST_BIT) state_d = S_STOP;
          else                   bit_d   = bit_q + 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        // Hold off until the line recovers so a break is not read as 0x00 frames.
        baud_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign rx_busy     = busy_q;
  assign frame_err   = ferr_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: hand-driven 8N1 frames at 50 clocks per bit,
// a negedge monitor recording output pulses, and per-scenario checks.
module tb_uart_rx;

  localparam int BIT = 50;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         got_cyc_q[$];
  int         ferr_cnt = 0;
  int         both_hi = 0;
  int         wide_valid = 0;
  int         busy_cycles = 0;
  logic       prev_valid = 1'b0;
  logic       prev_busy = 1'b0;
  logic       busy_at_valid = 1'b0;
  logic       busy_before_valid = 1'b0;
  int         last_fall_cyc = 0;

  uart_rx dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_busy     (rx_busy),
    .frame_err   (frame_err),
    .dbg_state_o (dbg_state)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor
  always @(negedge clk) begin
    if (rx_valid) begin
      got_q.push_back(rx_data);
      got_cyc_q.push_back(cyc);
      busy_at_valid     = rx_busy;
      busy_before_valid = prev_busy;
      if (prev_valid) wide_valid++;
      if (frame_err)  both_hi++;
    end
    if (frame_err) ferr_cnt++;
    if (rx_busy)   busy_cycles++;
    prev_valid = rx_valid;
    prev_busy  = rx_busy;
  end

  // driver tasks: entered and left 1ns after a rising edge
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int stop_cycles, input logic stop_lvl);
    last_fall_cyc = cyc;
    rx = 1'b0;
    wait_cycles(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cycles(BIT);
    end
    rx = stop_lvl;
    wait_cycles(stop_cycles);
  endtask

  task automatic clear_scoreboard();
    exp_q.delete();
    got_q.delete();
    got_cyc_q.delete();
    ferr_cnt   = 0;
    both_hi    = 0;
    wide_valid = 0;
  endtask

  task automatic test_reset();
    rx    = 1'b1;
    reset = 1'b1;
    wait_cycles(3);
    checks++;
    if ({rx_data, rx_valid, rx_busy, frame_err, dbg_state} !== 14'h0) begin
      errors++;
      $display("FAIL reset_outputs: data=%h valid=%b busy=%b ferr=%b state=%0d required all zero",
               rx_data, rx_valid, rx_busy, frame_err, dbg_state);
    end
    reset = 1'b0;
    wait_cycles(5);
  endtask

  task automatic test_loopback();
    clear_scoreboard();
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, BIT, 1'b1);
    wait_cycles(20);
    checks++;
    if (got_q.size() !== 1) begin
      errors++;
      $display("FAIL loop_count: got %0d pulses required 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== exp_q[0]) begin
        errors++;
        $display("FAIL loop_data: got %h required %h", got_q[0], exp_q[0]);
      end
      checks++;
      if (got_cyc_q[0] - last_fall_cyc < 474 || got_cyc_q[0] - last_fall_cyc > 480) begin
        errors++;
        $display("FAIL loop_latency: got %0d required 474..480", got_cyc_q[0] - last_fall_cyc);
      end
      checks++;
      if (busy_at_valid !== 1'b0 || busy_before_valid !== 1'b1) begin
        errors++;
        $display("FAIL loop_busy_edge: busy at valid %b before %b required 0 and 1",
                 busy_at_valid, busy_before_valid);
      end
    end
    checks++;
    if (ferr_cnt !== 0 || wide_valid !== 0) begin
      errors++;
      $display("FAIL loop_pulses: ferr %0d wide %0d required 0 0", ferr_cnt, wide_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vec [3];
    vec[0] = 8'h00;
    vec[1] = 8'hFF;
    vec[2] = 8'h55;
    clear_scoreboard();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(vec[i]);
      send_frame(vec[i], BIT, 1'b1);
    end
    wait_cycles(20);
    checks++;
    if (got_q.size() !== 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d pulses required 3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL b2b_data%0d: got %h required %h", i, got_q[i], exp_q[i]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (got_cyc_q[i] - got_cyc_q[i-1] < 498 || got_cyc_q[i] - got_cyc_q[i-1] > 502) begin
          errors++;
          $display("FAIL b2b_spacing%0d: got %0d required 498..502", i,
                   got_cyc_q[i] - got_cyc_q[i-1]);
        end
      end
    end
    checks++;
    if (ferr_cnt !== 0 || wide_valid !== 0) begin
      errors++;
      $display("FAIL b2b_pulses: ferr %0d wide %0d required 0 0", ferr_cnt, wide_valid);
    end
  endtask

  task automatic test_glitch();
    clear_scoreboard();
    busy_cycles = 0;
    rx = 1'b0;
    wait_cycles(10);
    rx = 1'b1;
    wait_cycles(60);
    checks++;
    if (busy_cycles < 20 || busy_cycles > 26) begin
      errors++;
      $display("FAIL glitch_busy_len: got %0d cycles required 20..26", busy_cycles);
    end
    checks++;
    if (rx_busy !== 1'b0 || got_q.size() !== 0 || ferr_cnt !== 0) begin
      errors++;
      $display("FAIL glitch_quiet: busy %b pulses %0d ferr %0d required 0 0 0",
               rx_busy, got_q.size(), ferr_cnt);
    end
    send_frame(8'h3C, BIT, 1'b1);
    wait_cycles(20);
    checks++;
    if (got_q.size() !== 1 || got_q[0] !== 8'h3C) begin
      errors++;
      $display("FAIL glitch_follow: pulses %0d data %h required 1 3c", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 8'hxx);
    end
  endtask

  task automatic test_frame_err();
    clear_scoreboard();
    send_frame(8'h5A, BIT, 1'b1);
    wait_cycles(20);
    checks++;
    if (got_q.size() !== 1 || rx_data !== 8'h5A) begin
      errors++;
      $display("FAIL ferr_pre: pulses %0d data %h required 1 5a", got_q.size(), rx_data);
    end
    clear_scoreboard();
    send_frame(8'h3C, 2 * BIT, 1'b0);
    checks++;
    if (ferr_cnt !== 1 || got_q.size() !== 0 || both_hi !== 0) begin
      errors++;
      $display("FAIL ferr_pulse: ferr %0d valid %0d both %0d required 1 0 0",
               ferr_cnt, got_q.size(), both_hi);
    end
    checks++;
    if (rx_data !== 8'h5A) begin
      errors++;
      $display("FAIL ferr_data_held: got %h required 5a", rx_data);
    end
    rx = 1'b0;
    wait_cycles(BIT);
    checks++;
    if (rx_busy !== 1'b1) begin
      errors++;
      $display("FAIL ferr_busy_low_line: got %b required 1", rx_busy);
    end
    rx = 1'b1;
    wait_cycles(10);
    checks++;
    if (rx_busy !== 1'b0 || ferr_cnt !== 1 || got_q.size() !== 0) begin
      errors++;
      $display("FAIL ferr_recover: busy %b ferr %0d valid %0d required 0 1 0",
               rx_busy, ferr_cnt, got_q.size());
    end
    send_frame(8'h81, BIT, 1'b1);
    wait_cycles(20);
    checks++;
    if (got_q.size() !== 1 || rx_data !== 8'h81) begin
      errors++;
      $display("FAIL ferr_follow: pulses %0d data %h required 1 81", got_q.size(), rx_data);
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_scoreboard();
    // 0xF0: start, four low data bits, then reset halfway through bit 4
    rx = 1'b0;
    wait_cycles(5 * BIT);
    rx = 1'b1;
    wait_cycles(BIT / 2);
    reset = 1'b1;
    wait_cycles(1);
    reset = 1'b0;
    checks++;
    if ({rx_data, rx_valid, rx_busy, frame_err, dbg_state} !== 14'h0) begin
      errors++;
      $display("FAIL midreset_outputs: data=%h valid=%b busy=%b ferr=%b state=%0d required all zero",
               rx_data, rx_valid, rx_busy, frame_err, dbg_state);
    end
    wait_cycles(BIT / 2 - 1 + 3 * BIT + BIT + 100);
    checks++;
    if (got_q.size() !== 0 || ferr_cnt !== 0 || rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_quiet: valid %0d ferr %0d busy %b required 0 0 0",
               got_q.size(), ferr_cnt, rx_busy);
    end
    send_frame(8'h0F, BIT, 1'b1);
    wait_cycles(20);
    checks++;
    if (got_q.size() !== 1 || rx_data !== 8'h0F) begin
      errors++;
      $display("FAIL midreset_follow: pulses %0d data %h required 1 0f", got_q.size(), rx_data);
    end
  endtask

  initial begin
    rx    = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_loopback();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
